// File: rtl/ps2_kbd_device.sv
// PS2 keyboard device endpoint: drives the PS2 clock, sends queued scan bytes, receives host commands.
// Optional PS2_DEV_BAT_EN: enqueue a 0xAA BAT byte BAT_DELAY_US after reset release.
module ps2_kbd_device #(
  parameter int TXBUF_DEPTH_BITS = 3,
  parameter int HALFBIT_US       = 40,
  parameter int IDLE_US          = 50,
  parameter int HOLDOFF_US       = 50,
  parameter int BAT_DELAY_US     = 500
) (
  input  logic                      clk6x,
  input  logic                      resetn,
  input  logic                      ck1us,
  input  logic [7:0]                scan_wdata_i,
  input  logic                      scan_enq_i,
  output logic                      scan_full_o,
  output logic [TXBUF_DEPTH_BITS:0] scan_count_o,
  output logic [7:0]                cmd_rx_o,
  output logic                      cmd_rx_v_o,
  output logic                      cmd_perr_o,
  output logic                      busy_o,
  input  logic                      PS2_CLK,
  input  logic                      PS2_DATA,
  output logic                      PS2_CLKDR,
  output logic                      PS2_DATADR
);
  localparam int DEPTH = 1 << TXBUF_DEPTH_BITS;
  localparam int CW    = TXBUF_DEPTH_BITS + 1;
`ifdef PS2_DEV_BAT_EN
  localparam bit BAT_EN = 1'b1;
`else
  localparam bit BAT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, TX, RX, RX_ACK, HOLDOFF} state_t;
  state_t state_q, state_d;

  logic [1:0]  ck_sync, dt_sync;
  logic        clk_s, data_s;
  logic [15:0] ph_tmr, idle_cnt, bat_tmr;
  logic        phase_b, bat_sent, bat_enq;
  logic [3:0]  bit_idx;
  logic [9:0]  rx_sr;
  logic [7:0]  mem [DEPTH];
  logic [TXBUF_DEPTH_BITS-1:0] wp, rp;
  logic [CW-1:0] count;
  logic [7:0]  head, enq_data;
  logic [10:0] tx_frame;
  logic        ph_end, ho_end, host_req, rx_bad, enq, tx_done, rx_last;

  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      ck_sync <= 2'b11;
      dt_sync <= 2'b11;
    end else begin
      ck_sync <= {ck_sync[0], PS2_CLK};
      dt_sync <= {dt_sync[0], PS2_DATA};
    end
  end
  assign clk_s  = ck_sync[1];
  assign data_s = dt_sync[1];

  // FIFO head stays stable through a TX frame, so the frame is built straight from it
  assign head     = mem[rp];
  assign tx_frame = {1'b1, ~^head, head, 1'b0};
  assign ph_end   = ck1us && (ph_tmr == 16'(HALFBIT_US - 1));
  assign ho_end   = ck1us && (ph_tmr == 16'(HOLDOFF_US - 1));
  assign host_req = clk_s & ~data_s;
  // rx_sr = {stop, parity, data[7:0]}; odd parity over data+parity
  assign rx_bad   = ~rx_sr[9] | ~(^rx_sr[8:0]);

  always_comb begin
    state_d = state_q;
    tx_done = 1'b0;
    rx_last = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (host_req) state_d = RX;
        else if (count != '0 && idle_cnt >= 16'(IDLE_US)) state_d = TX;
      end
      TX: if (ph_end) begin
        if (!phase_b && bit_idx <= 4'd9 && !clk_s) state_d = IDLE;
        else if (phase_b && bit_idx == 4'd10) begin
          state_d = HOLDOFF;
          tx_done = 1'b1;
        end
      end
      RX: if (ph_end && phase_b && bit_idx == 4'd10) begin
        if (rx_sr[9]) state_d = RX_ACK;
        else begin
          state_d = HOLDOFF;
          rx_last = 1'b1;
        end
      end
      RX_ACK: if (ph_end && phase_b) begin
        state_d = HOLDOFF;
        rx_last = 1'b1;
      end
      HOLDOFF: if (ho_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      ph_tmr   <= '0;
      phase_b  <= 1'b0;
      bit_idx  <= '0;
      rx_sr    <= '0;
      idle_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        ph_tmr  <= '0;
        phase_b <= 1'b0;
        bit_idx <= '0;
      end else if (ck1us && state_q != IDLE) begin
        if (ph_end && state_q != HOLDOFF) begin
          ph_tmr  <= '0;
          phase_b <= ~phase_b;
          if (phase_b) bit_idx <= bit_idx + 1'b1;
        end else begin
          ph_tmr <= ph_tmr + 1'b1;
        end
      end
      // start bit (pulse 1) is not captured
      if (state_q == RX && ph_end && !phase_b && bit_idx != 4'd0)
        rx_sr <= {data_s, rx_sr[9:1]};
      if (state_q != IDLE || !(clk_s && data_s) || bat_enq) idle_cnt <= '0;
      else if (ck1us && idle_cnt < 16'(IDLE_US)) idle_cnt <= idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      cmd_rx_o   <= 8'h00;
      cmd_rx_v_o <= 1'b0;
      cmd_perr_o <= 1'b0;
    end else begin
      cmd_rx_v_o <= rx_last & ~rx_bad;
      cmd_perr_o <= rx_last & rx_bad;
      if (rx_last && !rx_bad) cmd_rx_o <= rx_sr[7:0];
    end
  end

  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      bat_tmr  <= '0;
      bat_sent <= 1'b0;
    end else if (BAT_EN && !bat_sent && ck1us) begin
      if (bat_tmr == 16'(BAT_DELAY_US - 1)) bat_sent <= 1'b1;
      else bat_tmr <= bat_tmr + 1'b1;
    end
  end
  assign bat_enq = BAT_EN && !bat_sent && ck1us && (bat_tmr == 16'(BAT_DELAY_US - 1));

  assign scan_full_o  = (count == CW'(DEPTH));
  assign scan_count_o = count;
  assign enq          = (scan_enq_i | bat_enq) & ~scan_full_o;
  assign enq_data     = bat_enq ? 8'hAA : scan_wdata_i;

  // completion of a host command flushes the queue; a bad frame leaves only the 0xFE retry request
  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (rx_last) begin
      rp    <= '0;
      wp    <= TXBUF_DEPTH_BITS'(rx_bad);
      count <= CW'(rx_bad);
    end else begin
      if (enq) wp <= wp + 1'b1;
      if (tx_done) rp <= rp + 1'b1;
      if (enq && !tx_done) count <= count + 1'b1;
      else if (!enq && tx_done) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk6x) begin
    if (rx_last && rx_bad) mem[0] <= 8'hFE;
    else if (!rx_last && enq) mem[wp] <= enq_data;
  end

  assign busy_o     = (state_q != IDLE);
  assign PS2_CLKDR  = (state_q == TX || state_q == RX || state_q == RX_ACK) && phase_b;
  assign PS2_DATADR = (state_q == TX && !tx_frame[bit_idx]) || (state_q == RX_ACK);
endmodule

// File: tb/tb_ps2_kbd_device.sv
// Directed bench for ps2_kbd_device: models the host side of the open-collector PS2 lines.
`timescale 1ns/1ps
module tb_ps2_kbd_device;
  localparam int US = 4;  // clk6x cycles per ck1us pulse in this bench

  logic       clk6x = 1'b0, resetn = 1'b0, ck1us = 1'b0;
  logic [7:0] scan_wdata_i = 8'h00;
  logic       scan_enq_i = 1'b0;
  logic       scan_full_o, cmd_rx_v_o, cmd_perr_o, busy_o;
  logic [3:0] scan_count_o;
  logic [7:0] cmd_rx_o;
  logic       PS2_CLK, PS2_DATA, PS2_CLKDR, PS2_DATADR;
  logic       host_clk_lo = 1'b0, host_data_lo = 1'b0;

  int n_chk = 0, n_fail = 0;
  int div = 0, cyc = 0, rel_cyc = 0, first_rise = -1;
  int v_cyc = 0, perr_cyc = 0;

  ps2_kbd_device dut (
    .clk6x(clk6x), .resetn(resetn), .ck1us(ck1us),
    .scan_wdata_i(scan_wdata_i), .scan_enq_i(scan_enq_i),
    .scan_full_o(scan_full_o), .scan_count_o(scan_count_o),
    .cmd_rx_o(cmd_rx_o), .cmd_rx_v_o(cmd_rx_v_o), .cmd_perr_o(cmd_perr_o),
    .busy_o(busy_o), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
    .PS2_CLKDR(PS2_CLKDR), .PS2_DATADR(PS2_DATADR)
  );

  assign PS2_CLK  = ~(PS2_CLKDR | host_clk_lo);
  assign PS2_DATA = ~(PS2_DATADR | host_data_lo);

  always #10 clk6x = ~clk6x;
  always @(posedge clk6x) begin
    cyc++;
    #2;
    div   = (div == US - 1) ? 0 : div + 1;
    ck1us = (div == 0);
  end
  always @(negedge clk6x) begin
    if (cmd_rx_v_o) v_cyc++;
    if (cmd_perr_o) perr_cyc++;
    if (PS2_CLKDR && first_rise < 0) first_rise = cyc;
  end

  task automatic wait_us(input int n);
    repeat (n * US) @(negedge clk6x);
  endtask

  task automatic enq(input logic [7:0] d);
    @(negedge clk6x);
    scan_wdata_i = d;
    scan_enq_i   = 1'b1;
    @(negedge clk6x);
    scan_enq_i   = 1'b0;
  endtask

  // waits for the device to start driving CLK low
  task automatic wait_fall(input int max_us, output bit ok);
    bit prev;
    prev = PS2_CLKDR;
    ok   = 1'b0;
    for (int i = 0; i < max_us * US; i++) begin
      @(negedge clk6x);
      if (PS2_CLKDR && !prev) begin
        ok = 1'b1;
        break;
      end
      prev = PS2_CLKDR;
    end
  endtask

  task automatic get_frame(output logic [10:0] f, output bit ok, output int w0);
    bit o;
    f = '0; ok = 1'b1; w0 = 0;
    for (int k = 0; k < 11; k++) begin
      wait_fall(k == 0 ? 1500 : 120, o);
      if (!o) begin
        ok = 1'b0;
        return;
      end
      f[k] = PS2_DATA;
      if (k == 0)
        for (int g = 0; g < 200 * US && PS2_CLKDR; g++) begin
          if (ck1us) w0++;
          @(negedge clk6x);
        end
    end
  endtask

  task automatic host_send(input logic [7:0] d, input logic par, input logic stop,
                           output bit ack, output bit ok);
    logic [9:0] seq;
    bit o;
    seq = {stop, par, d};
    ack = 1'b0; ok = 1'b1;
    host_clk_lo = 1'b1;
    wait_us(110);
    host_data_lo = 1'b1;
    wait_us(5);
    host_clk_lo = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      wait_fall(150, o);
      if (!o) begin
        ok = 1'b0;
        host_data_lo = 1'b0;
        return;
      end
      host_data_lo = (k <= 10) ? ~seq[k-1] : 1'b0;
    end
    if (stop) begin
      wait_fall(150, o);
      if (!o) ok = 1'b0;
      else ack = PS2_DATADR;
    end
    wait_us(45);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk6x);
    n_chk++; if (PS2_CLKDR !== 1'b0 || PS2_DATADR !== 1'b0) begin n_fail++; $display("FAIL reset_drives: got clkdr=%b datadr=%b expected 0 0", PS2_CLKDR, PS2_DATADR); end
    n_chk++; if (scan_count_o !== 4'd0 || scan_full_o !== 1'b0) begin n_fail++; $display("FAIL reset_fifo: got count=%0d full=%b expected 0 0", scan_count_o, scan_full_o); end
    n_chk++; if (cmd_rx_o !== 8'h00 || cmd_rx_v_o !== 1'b0 || cmd_perr_o !== 1'b0) begin n_fail++; $display("FAIL reset_cmd: got cmd=%h v=%b perr=%b expected 00 0 0", cmd_rx_o, cmd_rx_v_o, cmd_perr_o); end
    n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    @(negedge clk6x);
    resetn  = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic test_bat();
`ifdef PS2_DEV_BAT_EN
    logic [10:0] f; bit ok; int w;
    get_frame(f, ok, w);
    n_chk++; if (f !== 11'h754) begin n_fail++; $display("FAIL bat_frame: got %h (ok=%b) expected 754", f, ok); end
    n_chk++; if (first_rise - rel_cyc < 550 * US) begin n_fail++; $display("FAIL bat_delay: got %0d cycles expected >= %0d", first_rise - rel_cyc, 550 * US); end
    wait_us(150);
`else
    wait_us(2000);
    n_chk++; if (first_rise != -1) begin n_fail++; $display("FAIL bat_none: got clk activity at cycle %0d expected none", first_rise); end
    n_chk++; if (busy_o !== 1'b0 || scan_count_o !== 4'd0) begin n_fail++; $display("FAIL bat_idle: got busy=%b count=%0d expected 0 0", busy_o, scan_count_o); end
`endif
  endtask

  task automatic test_tx_basic();
    logic [10:0] f; bit ok; int w;
    enq(8'h1C);
    n_chk++; if (scan_count_o !== 4'd1) begin n_fail++; $display("FAIL tx_count_pre: got %0d expected 1", scan_count_o); end
    get_frame(f, ok, w);
    n_chk++; if (f !== 11'h438) begin n_fail++; $display("FAIL tx_frame: got %h (ok=%b) expected 438", f, ok); end
    n_chk++; if (w != 40) begin n_fail++; $display("FAIL tx_low_width: got %0d us expected 40", w); end
    n_chk++; if (scan_count_o !== 4'd1) begin n_fail++; $display("FAIL tx_count_stop: got %0d expected 1", scan_count_o); end
    for (int g = 0; g < 60 * US && PS2_CLKDR; g++) @(negedge clk6x);
    wait_us(2);
    n_chk++; if (scan_count_o !== 4'd0 || busy_o !== 1'b1) begin n_fail++; $display("FAIL tx_holdoff: got count=%0d busy=%b expected 0 1", scan_count_o, busy_o); end
    wait_us(60);
    n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL tx_idle: got busy=%b expected 0", busy_o); end
  endtask

  task automatic test_rx_cmd();
    bit ack, ok; int v0, p0;
    v0 = v_cyc; p0 = perr_cyc;
    host_clk_lo = 1'b1;
    wait_us(20);
    enq(8'h1C);
    n_chk++; if (scan_count_o !== 4'd1) begin n_fail++; $display("FAIL rx_prequeue: got %0d expected 1", scan_count_o); end
    host_send(8'hED, 1'b1, 1'b1, ack, ok);
    n_chk++; if (!ok || ack !== 1'b1) begin n_fail++; $display("FAIL rx_ack: got ack=%b ok=%b expected 1 1", ack, ok); end
    n_chk++; if (v_cyc - v0 != 1) begin n_fail++; $display("FAIL rx_valid_pulse: got %0d cycles expected 1", v_cyc - v0); end
    n_chk++; if (cmd_rx_o !== 8'hED) begin n_fail++; $display("FAIL rx_cmd: got %h expected ed", cmd_rx_o); end
    n_chk++; if (scan_count_o !== 4'd0) begin n_fail++; $display("FAIL rx_flush: got %0d expected 0", scan_count_o); end
    n_chk++; if (perr_cyc != p0) begin n_fail++; $display("FAIL rx_no_perr: got %0d expected %0d", perr_cyc, p0); end
    wait_us(200);
  endtask

  task automatic test_rx_parity_err();
    bit ack, ok; int v0, p0, w; logic [10:0] f;
    v0 = v_cyc; p0 = perr_cyc;
    host_send(8'hED, 1'b0, 1'b1, ack, ok);
    n_chk++; if (!ok || ack !== 1'b1) begin n_fail++; $display("FAIL perr_ack: got ack=%b ok=%b expected 1 1", ack, ok); end
    n_chk++; if (perr_cyc - p0 != 1) begin n_fail++; $display("FAIL perr_pulse: got %0d cycles expected 1", perr_cyc - p0); end
    n_chk++; if (v_cyc != v0 || cmd_rx_o !== 8'hED) begin n_fail++; $display("FAIL perr_cmd_hold: got v=%0d cmd=%h expected v=%0d cmd=ed", v_cyc - v0, cmd_rx_o, 0); end
    n_chk++; if (scan_count_o !== 4'd1) begin n_fail++; $display("FAIL perr_fe_queued: got %0d expected 1", scan_count_o); end
    get_frame(f, ok, w);
    n_chk++; if (f !== 11'h5FC) begin n_fail++; $display("FAIL perr_fe_frame: got %h (ok=%b) expected 5fc", f, ok); end
    wait_us(200);
  endtask

  task automatic test_rx_stop_err();
    bit ack, ok, o; int p0, w; logic [10:0] f;
    p0 = perr_cyc;
    host_send(8'h5A, 1'b1, 1'b0, ack, ok);
    n_chk++; if (!ok || perr_cyc - p0 != 1) begin n_fail++; $display("FAIL stop_err_perr: got %0d pulses ok=%b expected 1", perr_cyc - p0, ok); end
    wait_fall(60, o);
    n_chk++; if (o) begin n_fail++; $display("FAIL stop_err_no_ack: got pulse 12 expected none"); end
    get_frame(f, ok, w);
    n_chk++; if (f !== 11'h5FC) begin n_fail++; $display("FAIL stop_err_fe_frame: got %h (ok=%b) expected 5fc", f, ok); end
    wait_us(200);
  endtask

  task automatic test_inhibit();
    bit o; logic [10:0] f; bit ok; int w;
    enq(8'h1C);
    for (int k = 0; k < 4; k++) wait_fall(1500, o);
    for (int g = 0; g < 60 * US && PS2_CLKDR; g++) @(negedge clk6x);
    wait_us(10);
    host_clk_lo = 1'b1;
    wait_us(40);
    n_chk++; if (PS2_CLKDR !== 1'b0 || PS2_DATADR !== 1'b0) begin n_fail++; $display("FAIL inh_release: got clkdr=%b datadr=%b expected 0 0", PS2_CLKDR, PS2_DATADR); end
    n_chk++; if (scan_count_o !== 4'd1 || busy_o !== 1'b0) begin n_fail++; $display("FAIL inh_keep: got count=%0d busy=%b expected 1 0", scan_count_o, busy_o); end
    wait_us(50);
    host_clk_lo = 1'b0;
    get_frame(f, ok, w);
    n_chk++; if (f !== 11'h438) begin n_fail++; $display("FAIL inh_resend: got %h (ok=%b) expected 438", f, ok); end
    wait_us(100);
    n_chk++; if (scan_count_o !== 4'd0) begin n_fail++; $display("FAIL inh_done: got %0d expected 0", scan_count_o); end
  endtask

  task automatic test_fifo_full();
    logic [10:0] f, exp_f; logic [7:0] d; bit ok, o; int w;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk6x);
      if (i == 9) begin
        n_chk++; if (scan_full_o !== 1'b1 || scan_count_o !== 4'd8) begin n_fail++; $display("FAIL fifo_full8: got full=%b count=%0d expected 1 8", scan_full_o, scan_count_o); end
      end
      scan_wdata_i = 8'(i);
      scan_enq_i   = 1'b1;
    end
    @(negedge clk6x);
    scan_enq_i = 1'b0;
    n_chk++; if (scan_count_o !== 4'd8) begin n_fail++; $display("FAIL fifo_drop9: got %0d expected 8", scan_count_o); end
    for (int i = 1; i <= 8; i++) begin
      d = 8'(i);
      exp_f = {1'b1, ~^d, d, 1'b0};
      get_frame(f, ok, w);
      n_chk++; if (f !== exp_f) begin n_fail++; $display("FAIL fifo_frame%0d: got %h (ok=%b) expected %h", i, f, ok, exp_f); end
    end
    wait_fall(250, o);
    n_chk++; if (o || scan_count_o !== 4'd0) begin n_fail++; $display("FAIL fifo_empty: got extra=%b count=%0d expected 0 0", o, scan_count_o); end
  endtask

  task automatic test_reset_midframe();
    bit o;
    wait_us(100);
    enq(8'h00);
    wait_fall(1500, o);
    @(negedge clk6x);
    #3 resetn = 1'b0;
    #1;
    n_chk++; if (!o || PS2_CLKDR !== 1'b0 || PS2_DATADR !== 1'b0) begin n_fail++; $display("FAIL rst_async: got clkdr=%b datadr=%b ok=%b expected 0 0", PS2_CLKDR, PS2_DATADR, o); end
    @(negedge clk6x);
    resetn = 1'b1;
    @(negedge clk6x);
    n_chk++; if (scan_count_o !== 4'd0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_state: got count=%0d busy=%b expected 0 0", scan_count_o, busy_o); end
  endtask

  initial begin
    test_reset();
    test_bat();
    test_tx_basic();
    test_rx_cmd();
    test_rx_parity_err();
    test_rx_stop_err();
    test_inhibit();
    test_fifo_full();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
